// File: rtl/matrix_unit_csr_ctrl_pkg.sv
// Shared constants for the matrix unit CSR agent: register map, bit indices,
// launcher FSM states and the debug read patterns.
package matrix_unit_csr_pkg;

  localparam int unsigned CSR_ADDR_CTRL        = 0;
  localparam int unsigned CSR_ADDR_STATUS      = 1;
  localparam int unsigned CSR_ADDR_JOB_ADDR    = 2;
  localparam int unsigned CSR_ADDR_DONE_CNT    = 3;
  localparam int unsigned CSR_ADDR_IRQ         = 4;
  localparam int unsigned CSR_ADDR_LAST_CYCLES = 5;

  localparam int unsigned CTRL_PUSH     = 0;
  localparam int unsigned CTRL_CLR_DONE = 1;
  localparam int unsigned CTRL_FLUSH    = 2;

  localparam int unsigned STAT_READY     = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_FULL      = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_BUSY      = 4;
  localparam int unsigned STAT_COUNT_LSB = 8;

  localparam int unsigned IRQ_PENDING = 0;
  localparam int unsigned IRQ_ENABLE  = 1;

  localparam logic [31:0] CSR_DBG_UNMAPPED = 32'hAAAA_AAAA;
  localparam logic [31:0] CSR_DBG_NO_CS    = 32'hCCCC_CCCC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SETTLE,
    ST_RUN
  } mu_state_e;

endpackage

// File: rtl/matrix_unit_csr_ctrl_if.sv
// AVMM CSR agent bus between host and the matrix unit CSR controller.
interface matrix_unit_csr_ctrl_if #(
  parameter int unsigned csr_addr_w = 8,
  parameter int unsigned csr_data_w = 32
);
  logic [csr_addr_w-1:0] avmm_a_csr_address_i;
  logic                  avmm_a_csr_chipselect_i;
  logic                  avmm_a_csr_write_i;
  logic [csr_data_w-1:0] avmm_a_csr_writedata_i;
  logic [csr_data_w-1:0] avmm_a_csr_readdata_o;

  modport master (
    output avmm_a_csr_address_i, avmm_a_csr_chipselect_i, avmm_a_csr_write_i,
           avmm_a_csr_writedata_i,
    input  avmm_a_csr_readdata_o
  );

  modport slave (
    input  avmm_a_csr_address_i, avmm_a_csr_chipselect_i, avmm_a_csr_write_i,
           avmm_a_csr_writedata_i,
    output avmm_a_csr_readdata_o
  );
endinterface

// File: rtl/matrix_unit_csr_ctrl_mu_job_fifo.sv
// Circular job queue of IMEM start addresses; flush is applied before a
// same-cycle push, and a push into a full queue is dropped.
module mu_job_fifo #(
  parameter int unsigned depth = 4,
  parameter int unsigned width = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [width-1:0]           din,
  output logic [$clog2(depth):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic [width-1:0]           head
);
  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = ptr_w + 1;

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] rd_q, wr_q, wr_base;
  logic             push_ok, pop_ok;

  assign full    = (count == cnt_w'(depth));
  assign empty   = (count == '0);
  assign push_ok = push && (flush || !full);
  assign pop_ok  = pop && !empty && !flush;
  assign wr_base = flush ? '0 : wr_q;
  assign head    = mem[rd_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      count <= '0;
    end else begin
      rd_q  <= flush ? '0 : rd_q + ptr_w'(pop_ok);
      wr_q  <= wr_base + ptr_w'(push_ok);
      count <= (flush ? '0 : count) + cnt_w'(push_ok) - cnt_w'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_base] <= din;
  end
endmodule

// File: rtl/matrix_unit_csr_ctrl.sv
// CSR agent and job launcher for the matrix unit. Define MU_CSR_PERF_EN to
// add the per-job cycle counter behind LAST_CYCLES.
module matrix_unit_csr_ctrl
  import matrix_unit_csr_pkg::*;
#(
  parameter int unsigned csr_addr_w  = 8,
  parameter int unsigned csr_data_w  = 32,
  parameter int unsigned imem_w_addr = 5,
  parameter int unsigned job_depth   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  matrix_unit_csr_ctrl_if.slave  csr,
  output logic                   mu_start_o,
  output logic [imem_w_addr-1:0] mu_job_addr_o,
  input  logic                   mu_ready_i,
  output logic                   irq_o
);
  localparam int unsigned cnt_w = $clog2(job_depth) + 1;

  mu_state_e             state_q, state_d;
  logic                  pop, job_done;
  logic                  wr_en, push, flush, clr_done;
  logic [csr_data_w-1:0] wdata, status, rd_mux;
  logic [imem_w_addr-1:0] job_addr_q, fifo_head;
  logic [cnt_w-1:0]      fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [csr_data_w-1:0] done_cnt_q;
  logic                  irq_pend_q, irq_en_q, ovf_q;
  logic                  unused_wdata;

  assign wdata        = csr.avmm_a_csr_writedata_i;
  assign unused_wdata = ^wdata;
  assign wr_en        = csr.avmm_a_csr_chipselect_i && csr.avmm_a_csr_write_i;

  function automatic logic wr_hit(input logic en, input logic [csr_addr_w-1:0] a,
                                  input int unsigned reg_addr);
    return en && (a == csr_addr_w'(reg_addr));
  endfunction

  assign push     = wr_hit(wr_en, csr.avmm_a_csr_address_i, CSR_ADDR_CTRL) && wdata[CTRL_PUSH];
  assign flush    = wr_hit(wr_en, csr.avmm_a_csr_address_i, CSR_ADDR_CTRL) && wdata[CTRL_FLUSH];
  assign clr_done = wr_hit(wr_en, csr.avmm_a_csr_address_i, CSR_ADDR_CTRL) && wdata[CTRL_CLR_DONE];

  mu_job_fifo #(.depth(job_depth), .width(imem_w_addr)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (job_addr_q),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full),
    .head  (fifo_head)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    job_done   = 1'b0;
    mu_start_o = 1'b0;
    unique case (state_q)
      ST_IDLE: if (!fifo_empty && mu_ready_i) begin
        pop     = 1'b1;
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        mu_start_o = 1'b1;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_RUN;
      ST_RUN: if (mu_ready_i) begin
        job_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MU_CSR_PERF_EN
  logic [csr_data_w-1:0] perf_cnt_q, perf_inc, last_cycles_q;
  // The completion cycle itself is counted, so LAST_CYCLES takes the incremented value.
  assign perf_inc = (&perf_cnt_q) ? perf_cnt_q : perf_cnt_q + csr_data_w'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cnt_q    <= '0;
      last_cycles_q <= '0;
    end else begin
      if (state_q == ST_LAUNCH) perf_cnt_q <= '0;
      else if (state_q == ST_SETTLE || state_q == ST_RUN) perf_cnt_q <= perf_inc;
      if (job_done) last_cycles_q <= perf_inc;
    end
  end
`endif

  always_comb begin
    status                              = '0;
    status[STAT_READY]                  = mu_ready_i;
    status[STAT_EMPTY]                  = fifo_empty;
    status[STAT_FULL]                   = fifo_full;
    status[STAT_OVF]                    = ovf_q;
    status[STAT_BUSY]                   = (state_q != ST_IDLE);
    status[STAT_COUNT_LSB +: 8]         = 8'(fifo_count);
  end

  always_comb begin
    rd_mux = CSR_DBG_UNMAPPED[csr_data_w-1:0];
    case (csr.avmm_a_csr_address_i)
      csr_addr_w'(CSR_ADDR_CTRL):     rd_mux = '0;
      csr_addr_w'(CSR_ADDR_STATUS):   rd_mux = status;
      csr_addr_w'(CSR_ADDR_JOB_ADDR): rd_mux = csr_data_w'(job_addr_q);
      csr_addr_w'(CSR_ADDR_DONE_CNT): rd_mux = done_cnt_q;
      csr_addr_w'(CSR_ADDR_IRQ):      rd_mux = csr_data_w'({irq_en_q, irq_pend_q});
`ifdef MU_CSR_PERF_EN
      csr_addr_w'(CSR_ADDR_LAST_CYCLES): rd_mux = last_cycles_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csr.avmm_a_csr_readdata_o <= '0;
      mu_job_addr_o             <= '0;
      job_addr_q                <= '0;
      done_cnt_q                <= '0;
      irq_pend_q                <= 1'b0;
      irq_en_q                  <= 1'b0;
      ovf_q                     <= 1'b0;
    end else begin
      if (!csr.avmm_a_csr_chipselect_i)
        csr.avmm_a_csr_readdata_o <= CSR_DBG_NO_CS[csr_data_w-1:0];
      else if (!csr.avmm_a_csr_write_i)
        csr.avmm_a_csr_readdata_o <= rd_mux;

      if (pop) mu_job_addr_o <= fifo_head;
      if (wr_hit(wr_en, csr.avmm_a_csr_address_i, CSR_ADDR_JOB_ADDR))
        job_addr_q <= wdata[imem_w_addr-1:0];

      // Completion beats both CLR_DONE and the pending-bit W1C.
      if (job_done)      done_cnt_q <= clr_done ? csr_data_w'(1) : done_cnt_q + csr_data_w'(1);
      else if (clr_done) done_cnt_q <= '0;

      if (job_done) irq_pend_q <= 1'b1;
      else if (wr_hit(wr_en, csr.avmm_a_csr_address_i, CSR_ADDR_IRQ) && wdata[IRQ_PENDING])
        irq_pend_q <= 1'b0;
      if (wr_hit(wr_en, csr.avmm_a_csr_address_i, CSR_ADDR_IRQ))
        irq_en_q <= wdata[IRQ_ENABLE];

      if (push && fifo_full && !flush) ovf_q <= 1'b1;
      else if (wr_hit(wr_en, csr.avmm_a_csr_address_i, CSR_ADDR_STATUS) && wdata[STAT_OVF])
        ovf_q <= 1'b0;
    end
  end

  assign irq_o = irq_pend_q && irq_en_q;
endmodule

// File: tb/tb_matrix_unit_csr_ctrl.sv
// Randomized self-checking bench for matrix_unit_csr_ctrl with a behavioural
// matrix unit responder and a queue-based job model.
module tb_matrix_unit_csr_ctrl;
  localparam int AW = 8, DW = 32, IW = 5, DEPTH = 4;
  localparam int A_CTRL = 0, A_STATUS = 1, A_JOB = 2, A_DONE = 3, A_IRQ = 4, A_LAST = 5;
  localparam logic [31:0] UNMAPPED = 32'hAAAA_AAAA;
  localparam logic [31:0] NO_CS    = 32'hCCCC_CCCC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_unit_csr_ctrl_if #(.csr_addr_w(AW), .csr_data_w(DW)) csr_bus ();
  logic          mu_start, irq;
  logic          mu_ready = 1'b1;
  logic [IW-1:0] mu_addr;

  matrix_unit_csr_ctrl #(
    .csr_addr_w(AW), .csr_data_w(DW), .imem_w_addr(IW), .job_depth(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .csr(csr_bus),
    .mu_start_o(mu_start), .mu_job_addr_o(mu_addr), .mu_ready_i(mu_ready), .irq_o(irq)
  );

  int n_checks = 0;
  int n_errors = 0;
  int unsigned cyc = 0;
  int exp_done = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Matrix unit model: after a start it holds ready low for busy_cfg sampled cycles.
  bit            hold = 1'b0;
  int            busy_cfg = 3;
  int            busy_left = 0;
  logic [IW-1:0] starts[$];
  int unsigned   start_cyc[$];

  always @(negedge clk) begin
    if (rst) begin
      busy_left = 0;
      mu_ready  = !hold;
    end else if (mu_start) begin
      starts.push_back(mu_addr);
      start_cyc.push_back(cyc);
      mu_ready  = 1'b0;
      busy_left = busy_cfg + 1;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) mu_ready = !hold;
    end else begin
      mu_ready = !hold;
    end
  end

  function automatic logic [31:0] exp_status(bit ready, int count, bit ovf, bit busy);
    logic [31:0] v = '0;
    v[0] = ready;
    v[1] = (count == 0);
    v[2] = (count == DEPTH);
    v[3] = ovf;
    v[4] = busy;
    v[15:8] = count[7:0];
    return v;
  endfunction

  function automatic logic [31:0] exp_last(int busy);
`ifdef MU_CSR_PERF_EN
    return 32'(busy + 1);
`else
    return UNMAPPED + 32'(busy - busy);
`endif
  endfunction

  task automatic csr_write(input int addr, input logic [DW-1:0] data);
    csr_bus.avmm_a_csr_address_i    = AW'(addr);
    csr_bus.avmm_a_csr_writedata_i  = data;
    csr_bus.avmm_a_csr_write_i      = 1'b1;
    csr_bus.avmm_a_csr_chipselect_i = 1'b1;
    @(negedge clk);
    csr_bus.avmm_a_csr_chipselect_i = 1'b0;
    csr_bus.avmm_a_csr_write_i      = 1'b0;
  endtask

  task automatic csr_read(input int addr, output logic [DW-1:0] data);
    csr_bus.avmm_a_csr_address_i    = AW'(addr);
    csr_bus.avmm_a_csr_write_i      = 1'b0;
    csr_bus.avmm_a_csr_chipselect_i = 1'b1;
    @(negedge clk);
    data = csr_bus.avmm_a_csr_readdata_o;
    csr_bus.avmm_a_csr_chipselect_i = 1'b0;
  endtask

  task automatic check_reg(input string tag, input int addr, input logic [31:0] exp);
    logic [DW-1:0] d;
    csr_read(addr, d);
    check_eq(tag, d, exp);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [DW-1:0] s;
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      csr_read(A_STATUS, s);
      if (!s[4] && s[1] && busy_left == 0) ok = 1'b1;
    end
    check_eq({tag, "_idle"}, ok, 1);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!mu_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_start"}, mu_start, 1);
  endtask

  // Fill the queue with the unit held busy, check STATUS, then release and
  // compare launches against the model queue.
  task automatic queue_round(input string tag, input int n_push, input int busy, input bit do_flush);
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] a;
    bit ovf = 1'b0;
    hold = 1'b1;
    repeat (2) @(negedge clk);
    starts.delete();
    start_cyc.delete();
    for (int i = 0; i < n_push; i++) begin
      a = IW'($urandom_range(0, 31));
      csr_write(A_JOB, DW'(a));
      if (do_flush && i == n_push - 1) begin
        csr_write(A_CTRL, 32'h5);
        exp_q.delete();
        exp_q.push_back(a);
      end else begin
        csr_write(A_CTRL, 32'h1);
        if (exp_q.size() < DEPTH) exp_q.push_back(a);
        else ovf = 1'b1;
      end
    end
    check_reg({tag, "_status"}, A_STATUS, exp_status(0, exp_q.size(), ovf, 0));
    csr_write(A_STATUS, 32'h8);
    check_reg({tag, "_ovf_clr"}, A_STATUS, exp_status(0, exp_q.size(), 0, 0));
    busy_cfg = busy;
    hold = 1'b0;
    wait_idle(tag, (busy + 4) * DEPTH + 20);
    check_eq({tag, "_nstarts"}, starts.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < starts.size()) check_eq({tag, "_order"}, starts[i], exp_q[i]);
      if (i > 0 && i < start_cyc.size())
        check_eq({tag, "_spacing"}, start_cyc[i] - start_cyc[i-1], busy + 3);
    end
    exp_done += exp_q.size();
    check_reg({tag, "_done"}, A_DONE, exp_done);
    check_reg({tag, "_last"}, A_LAST, exp_last(busy));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int unsigned w_edge;
    csr_bus.avmm_a_csr_address_i    = '0;
    csr_bus.avmm_a_csr_chipselect_i = 1'b0;
    csr_bus.avmm_a_csr_write_i      = 1'b0;
    csr_bus.avmm_a_csr_writedata_i  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_readdata", csr_bus.avmm_a_csr_readdata_o, 0);
    check_eq("rst_start", mu_start, 0);
    check_eq("rst_addr", mu_addr, 0);
    check_eq("rst_irq", irq, 0);
    rst = 1'b0;
    @(negedge clk);
    check_reg("rst_status", A_STATUS, exp_status(1, 0, 0, 0));
    check_reg("rst_done", A_DONE, 0);
    check_reg("rst_irqreg", A_IRQ, 0);

    // Single job, unit busy 10 cycles
    busy_cfg = 10;
    csr_write(A_JOB, 32'h0A);
    starts.delete();
    start_cyc.delete();
    w_edge = cyc + 1;
    csr_write(A_CTRL, 32'h1);
    wait_idle("single", 60);
    check_eq("single_nstarts", starts.size(), 1);
    if (starts.size() > 0) begin
      check_eq("single_latency", start_cyc[0] - w_edge, 1);
      check_eq("single_addr", starts[0], 5'h0A);
    end
    check_eq("single_addr_hold", mu_addr, 5'h0A);
    exp_done = 1;
    check_reg("single_done", A_DONE, exp_done);
    check_reg("single_last", A_LAST, exp_last(10));
    check_reg("single_jobaddr", A_JOB, 32'h0A);

    // Overflow: five pushes into a four-entry queue
    queue_round("ovf", 5, 2, 1'b0);

    // Completion and pending-bit W1C in the same cycle
    csr_write(A_IRQ, 32'h3);
    check_eq("irq_cleared", irq, 0);
    check_reg("irq_reg_en", A_IRQ, 32'h2);
    busy_cfg = 4;
    csr_write(A_JOB, 32'h11);
    csr_write(A_CTRL, 32'h1);
    wait_start("irq");
    repeat (5) @(negedge clk);
    check_eq("irq_pre", irq, 0);
    csr_write(A_IRQ, 32'h3);
    check_eq("irq_set_wins", irq, 1);
    check_reg("irq_reg_set", A_IRQ, 32'h3);
    exp_done++;
    check_reg("irq_done", A_DONE, exp_done);
    csr_write(A_IRQ, 32'h3);
    check_eq("irq_w1c", irq, 0);

    // Completion and CLR_DONE in the same cycle
    busy_cfg = 3;
    csr_write(A_CTRL, 32'h1);
    wait_start("clr");
    repeat (4) @(negedge clk);
    csr_write(A_CTRL, 32'h2);
    exp_done = 1;
    check_reg("clr_done_wins", A_DONE, exp_done);

    // FLUSH while the first of three jobs runs
    csr_write(A_CTRL, 32'h2);
    exp_done = 0;
    busy_cfg = 12;
    starts.delete();
    start_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      csr_write(A_JOB, 32'(i + 3));
      csr_write(A_CTRL, 32'h1);
    end
    csr_write(A_CTRL, 32'h4);
    wait_idle("flush", 60);
    check_eq("flush_nstarts", starts.size(), 1);
    exp_done = 1;
    check_reg("flush_done", A_DONE, exp_done);
    check_reg("flush_status", A_STATUS, exp_status(1, 0, 0, 0));

    // FLUSH and PUSH in one write, then randomized rounds
    queue_round("flushpush", 3, 3, 1'b1);
    for (int r = 0; r < 8; r++)
      queue_round("rand", $urandom_range(1, 6), $urandom_range(1, 6), ($urandom_range(0, 3) == 0));

    // Debug read patterns
    check_reg("unmapped_7f", 'h7F, UNMAPPED);
    check_reg("unmapped_06", 'h06, UNMAPPED);
    @(negedge clk);
    check_eq("no_cs", csr_bus.avmm_a_csr_readdata_o, NO_CS);

    // Reset mid-RUN with a second job queued
    busy_cfg = 30;
    starts.delete();
    csr_write(A_JOB, 32'h15);
    csr_write(A_CTRL, 32'h1);
    wait_start("rstrun");
    repeat (4) @(negedge clk);
    csr_write(A_CTRL, 32'h1);
    check_eq("rstrun_addr_pre", mu_addr, 5'h15);
    rst = 1'b1;
    #1;
    check_eq("rstrun_start", mu_start, 0);
    check_eq("rstrun_addr", mu_addr, 0);
    check_eq("rstrun_irq", irq, 0);
    check_eq("rstrun_readdata", csr_bus.avmm_a_csr_readdata_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    starts.delete();
    check_reg("rstrun_status", A_STATUS, 32'h3);
    check_reg("rstrun_done", A_DONE, 0);
    repeat (5) @(negedge clk);
    check_eq("rstrun_nostart", starts.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/matrix_unit_csr_ctrl.md
# matrix_unit_csr_ctrl

Parametrised CSR agent and job launcher for the matrix unit. Host software writes IMEM start addresses into a job queue over the AVMM CSR agent port. The block launches queued jobs one at a time through the matrix unit start/ready handshake, counts completions, raises an interrupt and optionally measures per-job cycle counts. It replaces the single start/ready CSR pair in the matrix unit wrapper.

## Interface
- csr_addr_w, 8, CSR word address width
- csr_data_w, 32, CSR data width (min 16)
- imem_w_addr, 5, job start address width (IMEM address)
- job_depth, 4, job queue entries (power of two, ≥2)
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- avmm_a_csr_address_i  in  csr_addr_w  CSR word address
- avmm_a_csr_chipselect_i  in  1  access strobe
- avmm_a_csr_write_i  in  1  1=write, 0=read
- avmm_a_csr_writedata_i  in  csr_data_w  write data
- avmm_a_csr_readdata_o  out  csr_data_w  read data, registered
- mu_start_o  out  1  one-cycle launch pulse to matrix unit
- mu_job_addr_o  out  imem_w_addr  start address of current job, stable from launch to completion
- mu_ready_i  in  1  matrix unit idle
- irq_o  out  1  level interrupt, completion pending

## Operation
- Register map (word addresses):
  - 0x00 CTRL, W:
    - bit0 PUSH: enqueue JOB_ADDR.
    - bit1 CLR_DONE: DONE_CNT := 0.
    - bit2 FLUSH: empty the queue; the running job is unaffected.
  - 0x01 STATUS, R:
    - bit0 mu_ready_i; bit1 queue empty; bit2 queue full; bit3 OVF sticky; bit4 busy (FSM≠IDLE).
    - [15:8] queue count; rest 0.
  - 0x02 JOB_ADDR, RW: imem_w_addr bits, zero-extended on read.
  - 0x03 DONE_CNT, R: completed jobs, wraps at 2^csr_data_w.
  - 0x04 IRQ, RW1C: bit0 pending, bit1 enable; write 1 to bit0 clears; bit1 written directly.
  - 0x05 LAST_CYCLES, R: see Configuration.
- Any other read address returns 0xAAAAAAAA (truncated to csr_data_w).
- Read without chipselect: readdata := 0xCCCCCCCC.
- Writes to read-only or unmapped addresses are ignored.
- Writing 1 to STATUS bit3 clears OVF.
- Queue: circular FIFO of job_depth entries.
  - PUSH when full: entry dropped, OVF := 1.
  - PUSH and pop in the same cycle: count unchanged, both take effect.
  - FLUSH and PUSH in the same write: flush first, then the push lands in the empty queue.
- FSM states IDLE, LAUNCH, SETTLE, RUN:
  - IDLE: if the queue is non-empty and mu_ready_i=1, pop the head into mu_job_addr_o and go to LAUNCH.
  - LAUNCH: mu_start_o=1 for exactly this cycle; go to SETTLE.
  - SETTLE: one cycle, absorbs the matrix unit ready drop; go to RUN.
  - RUN: on mu_ready_i=1, DONE_CNT+1, IRQ pending := 1, go to IDLE.
- irq_o = pending & enable.
- If a completion and a W1C of IRQ bit0 occur in the same cycle, the set wins.
- If a completion and CLR_DONE occur in the same cycle, DONE_CNT := 1.

## Timing
- Reset values:
  - readdata 0, mu_start_o 0, mu_job_addr_o 0, irq_o 0.
  - Queue empty, all registers 0, FSM IDLE.
- Reset asserted mid-job drops the job; outputs return to reset values immediately.
- Read latency is 1 cycle: readdata is valid the cycle after the chipselect read.
- Reads never stall; writes take effect on the next edge.
- PUSH into an empty queue with FSM IDLE and mu_ready_i=1:
  - count=1 the cycle after the write;
  - IDLE pops that cycle;
  - mu_start_o is high 2 cycles after the write edge.
- Back-to-back jobs have a minimum spacing of 4 cycles from start to start: LAUNCH, SETTLE, RUN≥1, IDLE.
- STATUS reflects register state as of the read-sampling edge.

## Configuration
- MU_CSR_PERF_EN defined:
  - A cycle counter clears at LAUNCH and increments every cycle in SETTLE and RUN.
  - It saturates at all-ones.
  - On completion it is copied to LAST_CYCLES.
- MU_CSR_PERF_EN undefined:
  - No counter logic.
  - LAST_CYCLES reads 0xAAAAAAAA, the same as an unmapped address.

## Structure
- Package matrix_unit_csr_pkg holds:
  - CSR address localparams (CSR_ADDR_CTRL … CSR_ADDR_LAST_CYCLES);
  - CTRL/STATUS/IRQ bit index constants;
  - the FSM state enum;
  - the debug constants 0xAAAAAAAA and 0xCCCCCCCC.
- One sub-module, mu_job_fifo, implements the parametrised queue:
  - inputs push, pop, flush;
  - outputs count, empty, full, head.

## Test plan
- Reset mid-RUN (job queued, mu_ready_i low) → mu_start_o 0, STATUS reads 0x00000003 with mu_ready_i=1, DONE_CNT 0.
- JOB_ADDR=0x0A, PUSH, model matrix unit busy 10 cycles → single start pulse 2 cycles after write, mu_job_addr_o=0x0A, DONE_CNT=1, LAST_CYCLES=11 (PERF_EN).
- Hold mu_ready_i low and push 5 jobs with job_depth=4 → STATUS full=1, OVF=1, count=4; then release → exactly 4 starts, in order.
- IRQ enable=1, run one job, then W1C IRQ bit0 in the completion cycle → irq_o remains 1 (set wins); a later W1C clears it.
- Queue 3 jobs, FLUSH during the first job → first job completes, no further starts, DONE_CNT=1.
- Read address 0x7F with chipselect → 0xAAAAAAAA; cycle with chipselect low → 0xCCCCCCCC; LAST_CYCLES without PERF_EN → 0xAAAAAAAA.
